// File: rtl/ps2_key_fifo.sv
// Packs decoded PS/2 characters into processor words, queues them in a FIFO,
// and exposes a pop-on-read data register plus a status register with sticky error flags.
module ps2_key_fifo #(
  parameter int WORD_SIZE     = 32,
  parameter int ASCII_SIZE    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int BASE_ADD      = 0,
  parameter int FLUSH_TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  keyValid,
  input  logic [ASCII_SIZE-1:0] keyData,
  input  logic                  keyError,
  input  logic [WORD_SIZE-1:0]  addIn,
  input  logic                  rdEn,
  output logic [WORD_SIZE-1:0]  dataOut,
  output logic                  irq,
  output logic                  overflow
);

  localparam int CPW  = WORD_SIZE / ASCII_SIZE;
  localparam int IDXW = (CPW > 2) ? $clog2(CPW) : 1;
  localparam int TW   = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic {EMPTY, PACKING} pack_state_t;

  pack_state_t           state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [WORD_SIZE-1:0]  word_q, word_d, lane_word;
  logic                  push, err_evt;
  logic [WORD_SIZE-1:0]  push_dat;

  logic [WORD_SIZE-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  err_q, ovf_q, irq_q;
  logic [WORD_SIZE-1:0]  dout_q, status;
  logic                  data_rd, stat_rd, pop, full, push_ok, drop;

  // Packer: keyError outranks keyValid, which outranks the idle timeout.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    word_d    = word_q;
    push      = 1'b0;
    push_dat  = word_q;
    err_evt   = 1'b0;
    lane_word = word_q;
    lane_word[idx_q*ASCII_SIZE +: ASCII_SIZE] = keyData;
    if (keyError) begin
      err_evt = 1'b1;
      state_d = EMPTY;
      idx_d   = '0;
      tmo_d   = '0;
      word_d  = '0;
    end else if (keyValid) begin
      tmo_d = '0;
      if (idx_q == IDXW'(CPW-1)) begin
        push     = 1'b1;
        push_dat = lane_word;
        word_d   = '0;
        idx_d    = '0;
        state_d  = EMPTY;
      end else begin
        word_d  = lane_word;
        idx_d   = idx_q + IDXW'(1);
        state_d = PACKING;
      end
    end else if (state_q == PACKING) begin
      if (tmo_q == TW'(FLUSH_TIMEOUT-1)) begin
        push     = 1'b1;
        push_dat = word_q;
        word_d   = '0;
        idx_d    = '0;
        tmo_d    = '0;
        state_d  = EMPTY;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  assign data_rd = rdEn && (addIn == WORD_SIZE'(BASE_ADD));
  assign stat_rd = rdEn && (addIn == WORD_SIZE'(BASE_ADD + 1));
  assign pop     = data_rd && (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign count_d = count_q + CW'(push_ok) - CW'(pop);

  always_comb begin
    status        = '0;
    status[15:8]  = 8'(count_q);
    status[7:3]   = 5'(idx_q);
    status[2]     = err_q;
    status[1]     = ovf_q;
    status[0]     = (count_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      idx_q    <= '0;
      tmo_q    <= '0;
      word_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      word_q  <= word_d;
      count_q <= count_d;
      irq_q   <= (count_d != '0);
      // A fresh event in the same cycle as a status read keeps the flag set.
      err_q   <= (err_q && !stat_rd) || err_evt;
      ovf_q   <= (ovf_q && !stat_rd) || drop;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (data_rd)      dout_q <= pop ? mem_q[rd_ptr_q] : '0;
      else if (stat_rd) dout_q <= status;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

  assign dataOut  = dout_q;
  assign irq      = irq_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: packing, timeout flush, overflow, full push+pop,
// keyError handling, empty read and asynchronous reset.
module tb_ps2_key_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        keyValid = 1'b0;
  logic [7:0]  keyData = '0;
  logic        keyError = 1'b0;
  logic [31:0] addIn = '0;
  logic        rdEn = 1'b0;
  logic [31:0] dataOut;
  logic        irq;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] DATA = 32'd0;
  localparam logic [31:0] STAT = 32'd1;

  ps2_key_fifo #(
    .WORD_SIZE(32), .ASCII_SIZE(8), .FIFO_DEPTH(4), .BASE_ADD(0), .FLUSH_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .keyValid(keyValid), .keyData(keyData), .keyError(keyError),
    .addIn(addIn), .rdEn(rdEn), .dataOut(dataOut), .irq(irq), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [7:0] d);
    keyValid = 1'b1;
    keyData  = d;
    @(posedge clk); #1;
    keyValid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    rdEn  = 1'b1;
    addIn = a;
    @(posedge clk); #1;
    rdEn  = 1'b0;
  endtask

  task automatic word(input logic [7:0] b);
    for (int j = 0; j < 4; j++) key(b + 8'(j));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #3;
    check("rst_dataOut", dataOut, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_ovf", {31'b0, overflow}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Packing
    key(8'h41); key(8'h42); key(8'h43); key(8'h44);
    check("pack_irq", {31'b0, irq}, 32'h1);
    rd(STAT);
    check("pack_status", dataOut, 32'h0000_0100);
    rd(DATA);
    check("pack_data", dataOut, 32'h4443_4241);
    check("pack_irq_after", {31'b0, irq}, 32'h0);
    rd(STAT);
    check("pack_status_empty", dataOut, 32'h0000_0001);

    // Timeout flush: push lands exactly 16 edges after the last keyValid
    key(8'h61); key(8'h62);
    idle(15);
    check("tmo_not_yet", {31'b0, irq}, 32'h0);
    idle(1);
    check("tmo_pushed", {31'b0, irq}, 32'h1);
    rd(DATA);
    check("tmo_data", dataOut, 32'h0000_6261);

    // Overflow: four words fill the FIFO, the fifth is dropped
    word(8'h10); word(8'h20); word(8'h30); word(8'h40);
    check("full_ovf_clear", {31'b0, overflow}, 32'h0);
    word(8'h90);
    check("ovf_set", {31'b0, overflow}, 32'h1);
    rd(STAT);
    check("ovf_status", dataOut, 32'h0000_0402);
    check("ovf_cleared_by_read", {31'b0, overflow}, 32'h0);
    rd(STAT);
    check("ovf_status2", dataOut, 32'h0000_0400);

    // Push and pop together while full
    key(8'h50); key(8'h51); key(8'h52);
    keyValid = 1'b1; keyData = 8'h53; rdEn = 1'b1; addIn = DATA;
    @(posedge clk); #1;
    keyValid = 1'b0; rdEn = 1'b0;
    check("pp_data", dataOut, 32'h1312_1110);
    check("pp_ovf", {31'b0, overflow}, 32'h0);
    rd(STAT);
    check("pp_status", dataOut, 32'h0000_0400);
    rd(DATA); check("pp_w2", dataOut, 32'h2322_2120);
    rd(DATA); check("pp_w3", dataOut, 32'h3332_3130);
    rd(DATA); check("pp_w4", dataOut, 32'h4342_4140);
    rd(DATA); check("pp_w5", dataOut, 32'h5352_5150);
    check("pp_irq_empty", {31'b0, irq}, 32'h0);

    // keyError discards a partial word
    key(8'h31); key(8'h32);
    rd(STAT);
    check("err_partial_status", dataOut, 32'h0000_0011);
    keyError = 1'b1;
    @(posedge clk); #1;
    keyError = 1'b0;
    rd(STAT);
    check("err_status", dataOut, 32'h0000_0005);
    rd(STAT);
    check("err_cleared", dataOut, 32'h0000_0001);
    idle(20);
    check("err_no_push", {31'b0, irq}, 32'h0);

    // keyError beats a simultaneous keyValid
    key(8'h71);
    keyValid = 1'b1; keyData = 8'h72; keyError = 1'b1;
    @(posedge clk); #1;
    keyValid = 1'b0; keyError = 1'b0;
    rd(STAT);
    check("err_vs_valid", dataOut, 32'h0000_0005);

    // Empty data read returns zero
    rd(DATA);
    check("empty_read", dataOut, 32'h0);

    // Asynchronous reset mid-word with two queued words
    word(8'h10); word(8'h20);
    key(8'hA0); key(8'hA1);
    rd(STAT);
    check("pre_rst_status", dataOut, 32'h0000_0210);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dataOut", dataOut, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd(STAT);
    check("post_rst_status", dataOut, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Parametrised keyboard receive buffer that sits between the PS/2 decoder and the processor's memory-mapped load path. It packs decoded ASCII key bytes into processor words and queues completed words in a FIFO of configurable depth. A partially filled word is flushed after an idle timeout. The block exposes a data register that pops the FIFO on read and a status register carrying occupancy and sticky error flags.

## Interface
- WORD_SIZE, 32, processor word width; must be an integer multiple of ASCII_SIZE
- ASCII_SIZE, 8, width of one key character
- FIFO_DEPTH, 4, FIFO depth in words; power of two, ≥2
- BASE_ADD, 0, data register address; status register is at BASE_ADD+1
- FLUSH_TIMEOUT, 1000000, idle clk cycles before a partial word is pushed; ≥1
- Derived: CPW = WORD_SIZE/ASCII_SIZE characters per word

- clk  in  1  single system clock; all logic is on posedge clk
- rst  in  1  asynchronous, active-high reset
- keyValid  in  1  one-cycle strobe from the PS/2 decoder, synchronous to clk; keyData is valid on this strobe
- keyData  in  ASCII_SIZE  decoded character
- keyError  in  1  one-cycle strobe: decoder parity/framing error
- addIn  in  WORD_SIZE  load address
- rdEn  in  1  load strobe; sampled together with addIn
- dataOut  out  WORD_SIZE  registered read data
- irq  out  1  high while the FIFO is non-empty
- overflow  out  1  sticky: a word was dropped because the FIFO was full

## Operation
- **Reset** (asynchronous): all of the following clear to 0 — FIFO pointers, count, packer lane index, timeout counter, partial word, dataOut, irq, overflow, and errFlag.
- **Packer states:**
  - EMPTY: lane index is 0.
  - PACKING: lane index is between 1 and CPW-1.
- **keyValid:**
  - keyData is written into lane `idx`, occupying bits [idx*ASCII_SIZE +: ASCII_SIZE]. The first character goes in the least significant lane.
  - The lane index increments and the timeout counter clears.
  - If this character fills lane CPW-1, the full word is pushed and the packer returns to EMPTY with the partial word cleared.
- **Timeout:**
  - In PACKING, the timeout counter increments on every cycle without keyValid.
  - When the counter reaches FLUSH_TIMEOUT, the partial word is pushed with unused lanes set to 0, and the packer returns to EMPTY.
  - In EMPTY, the counter holds at 0.
- **keyError:**
  - The partial word is discarded and the packer returns to EMPTY.
  - errFlag is set (sticky).
  - If keyError and keyValid arrive in the same cycle, keyError wins and the character is dropped.
- **Push when full:**
  - The word is dropped and overflow is set (sticky).
  - If a pop happens in the same cycle, the pop is applied first and the push succeeds; count is unchanged.
- **Data read** (rdEn with addIn==BASE_ADD):
  - If the FIFO is non-empty, dataOut receives the head word and the FIFO pops.
  - If the FIFO is empty, dataOut receives 0 and nothing pops.
  - A push in the same cycle as a read of an empty FIFO is not visible to that read.
- **Status read** (rdEn with addIn==BASE_ADD+1):
  - dataOut = {zero-extended count in bits [15:8], lane index in bits [7:3], errFlag in bit 2, overflow in bit 1, empty in bit 0}.
  - The read clears overflow and errFlag. A new overflow or error event in the same cycle wins, so the flag stays set.
- **Other addresses:** rdEn at any other address leaves dataOut unchanged and has no side effects.
- **Pointers:** read and write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. count is log2(FIFO_DEPTH)+1 bits wide, ranging 0 to FIFO_DEPTH.
- **irq:** irq = (count != 0), registered.

## Timing
- rdEn at edge N → dataOut valid after edge N and held until the next matching read.
- keyValid that completes a word at edge N → FIFO count and irq updated after N. A data read issued at N+1 returns the word after N+1.
- Timeout flush: if the last keyValid is at edge N, the push occurs at edge N+FLUSH_TIMEOUT.
- Back-to-back data reads pop one word per cycle.
- Reset asserted mid-operation clears everything immediately, including a partial word or a read in flight. dataOut reads 0 during reset.

## Test plan
- **Packing:** keyValid with 0x41, 0x42, 0x43, 0x44 (CPW=4) → count=1 and irq=1. A data read returns 0x44434241, after which count=0 and irq=0.
- **Timeout flush:** FLUSH_TIMEOUT=16; send 0x61, 0x62, then idle. The push occurs exactly 16 cycles after the last keyValid, and a data read returns 0x00006261.
- **Overflow:** fill 4 words, then complete a 5th → the 5th is dropped and overflow=1. A status read returns count=4 with overflow bit set. A second status read shows overflow=0.
- **Simultaneous push and pop when full:** the pop returns word 1, count stays 4, overflow stays 0, and subsequent reads return words 2, 3, 4, 5 in order.
- **keyError and empty read:**
  - Send 0x31, 0x32, then keyError → status shows lane index=0 and errFlag=1, and no word is pushed.
  - A data read while empty returns 0.
- **Asynchronous reset:** assert rst mid-word with FIFO count=2 → all outputs go to 0 without waiting for a clk edge, and count=0 after release.
